// File: rtl/completion_buffer_if.sv
// Bus bundle for completion_buffer: allocate, writeback, retire, flush and occupancy.
// master = decode/functional units/commit side, slave = the buffer itself.
interface completion_buffer_if #(
   parameter int NUM_ENTRY = 16,
   parameter int NUM_WB    = 4,
   parameter int DATA_W    = 32
);
   localparam int IDX_W = $clog2(NUM_ENTRY);

   logic                     alloc_req;
   logic [4:0]               alloc_rd;
   logic                     alloc_wen;
   logic                     alloc_ready;
   logic [IDX_W-1:0]         alloc_index;

   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*IDX_W-1:0]  wb_index;
   logic [NUM_WB*DATA_W-1:0] wb_data;
   logic [NUM_WB-1:0]        wb_exc;

   logic                     retire_valid;
   logic                     retire_ready;
   logic [4:0]               retire_rd;
   logic                     retire_wen;
   logic [DATA_W-1:0]        retire_data;
   logic                     retire_exc;
   logic [IDX_W-1:0]         retire_index;

   logic                     flush;
   logic [IDX_W:0]           count;

   modport master (
      output alloc_req, alloc_rd, alloc_wen,
      input  alloc_ready, alloc_index,
      output wb_valid, wb_index, wb_data, wb_exc,
      input  retire_valid, retire_rd, retire_wen, retire_data, retire_exc, retire_index,
      output retire_ready, flush,
      input  count
   );

   modport slave (
      input  alloc_req, alloc_rd, alloc_wen,
      output alloc_ready, alloc_index,
      input  wb_valid, wb_index, wb_data, wb_exc,
      output retire_valid, retire_rd, retire_wen, retire_data, retire_exc, retire_index,
      input  retire_ready, flush,
      output count
   );
endinterface

// File: rtl/completion_buffer.sv
// In-order completion buffer: entries are allocated at the tail in program order,
// completed out of order by NUM_WB writeback ports, and retired from the head.
// Optional macro CB_WB_FORWARD_EN forwards a writeback to the head entry straight
// onto the retire outputs in the same cycle.
module completion_buffer #(
   parameter int NUM_ENTRY = 16,
   parameter int NUM_WB    = 4,
   parameter int DATA_W    = 32
) (
   input logic            CLK,
   input logic            nRST,
   completion_buffer_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRY);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [IDX_W:0]        head, tail;
   logic [IDX_W-1:0]      head_idx, tail_idx;
   logic [NUM_ENTRY-1:0]  valid, done, wen_q, exc_q;
   logic [4:0]            rd_q   [NUM_ENTRY];
   logic [DATA_W-1:0]     data_q [NUM_ENTRY];

   logic                  full, alloc_fire, retire_fire;
   logic [NUM_ENTRY-1:0]  wb_hit, wb_sel_exc;
   logic [DATA_W-1:0]     wb_sel_data [NUM_ENTRY];
   logic                  head_rdy, head_exc;
   logic [DATA_W-1:0]     head_data;

   assign head_idx    = head[IDX_W-1:0];
   assign tail_idx    = tail[IDX_W-1:0];
   assign full        = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
   assign alloc_fire  = bus.alloc_req && !full;
   assign retire_fire = head_rdy && bus.retire_ready;

   assign bus.alloc_ready = !full;
   assign bus.alloc_index = tail_idx;
   assign bus.count       = tail - head;

   // Per-entry writeback select; scanning from the top port down lets port 0 win a collision.
   always_comb begin
      wb_hit     = '0;
      wb_sel_exc = '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
         wb_sel_data[e] = '0;
         for (int p = NUM_WB-1; p >= 0; p--) begin
            if (bus.wb_valid[p] && (bus.wb_index[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
               wb_hit[e]      = 1'b1;
               wb_sel_data[e] = bus.wb_data[p*DATA_W +: DATA_W];
               wb_sel_exc[e]  = bus.wb_exc[p];
            end
         end
      end
   end

   // Head readiness and payload, optionally bypassing a same-cycle writeback to the head.
   always_comb begin
      head_rdy  = valid[head_idx] && done[head_idx];
      head_data = data_q[head_idx];
      head_exc  = exc_q[head_idx];
`ifdef CB_WB_FORWARD_EN
      if (valid[head_idx] && !done[head_idx] && wb_hit[head_idx]) begin
         head_rdy  = 1'b1;
         head_data = wb_sel_data[head_idx];
         head_exc  = wb_sel_exc[head_idx];
      end
`endif
   end

   // Retire outputs read as zero whenever nothing is offered.
   assign bus.retire_valid = head_rdy;
   assign bus.retire_rd    = head_rdy ? rd_q[head_idx] : 5'd0;
   assign bus.retire_wen   = head_rdy && wen_q[head_idx];
   assign bus.retire_data  = head_rdy ? head_data : '0;
   assign bus.retire_exc   = head_rdy && head_exc;
   assign bus.retire_index = head_rdy ? head_idx : '0;

   // Buffer state: flush dominates; otherwise writeback, then retire, then allocate.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
         wen_q <= '0;
         exc_q <= '0;
         for (int e = 0; e < NUM_ENTRY; e++) begin
            rd_q[e]   <= '0;
            data_q[e] <= '0;
         end
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         for (int e = 0; e < NUM_ENTRY; e++) begin
            if (wb_hit[e] && valid[e]) begin
               done[e]   <= 1'b1;
               data_q[e] <= wb_sel_data[e];
               exc_q[e]  <= wb_sel_exc[e];
            end
         end
         if (retire_fire) begin
            valid[head_idx] <= 1'b0;
            done[head_idx]  <= 1'b0;
            head            <= head + (IDX_W+1)'(1);
         end
         if (alloc_fire) begin
            valid[tail_idx] <= 1'b1;
            done[tail_idx]  <= 1'b0;
            rd_q[tail_idx]  <= bus.alloc_rd;
            wen_q[tail_idx] <= bus.alloc_wen;
            tail            <= tail + (IDX_W+1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_completion_buffer.sv
// Self-checking bench for completion_buffer with a queue-based program-order model.
module tb_completion_buffer;
   localparam int N   = 16;
   localparam int NWB = 4;
   localparam int DW  = 32;
   localparam int IW  = 4;

   logic CLK;
   logic nRST;

   completion_buffer_if #(.NUM_ENTRY(N), .NUM_WB(NWB), .DATA_W(DW)) bus ();

   completion_buffer #(.NUM_ENTRY(N), .NUM_WB(NWB), .DATA_W(DW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [IW-1:0] idx;
      logic [4:0]    rd;
      logic          wen;
      logic          done;
      logic [DW-1:0] data;
      logic          exc;
   } ent_t;

   ent_t mq[$];
   int   tail_ptr;
   int   checks;
   int   errors;

   logic          exp_rv, exp_wen, exp_exc;
   logic [4:0]    exp_rd;
   logic [DW-1:0] exp_data;
   logic [IW-1:0] exp_ridx;

   // Two writeback ports aimed at one entry in the same cycle is illegal stimulus.
   always @(posedge CLK) begin
      if (nRST) begin
         for (int i = 0; i < NWB; i++)
            for (int j = i + 1; j < NWB; j++)
               assert (!(bus.wb_valid[i] && bus.wb_valid[j] &&
                         bus.wb_index[i*IW +: IW] == bus.wb_index[j*IW +: IW]))
                  else $error("writeback index collision between ports %0d and %0d", i, j);
      end
   end

   task automatic model_outputs();
      exp_rv = 1'b0; exp_rd = '0; exp_wen = 1'b0; exp_data = '0; exp_exc = 1'b0; exp_ridx = '0;
      if (mq.size() > 0) begin
         if (mq[0].done) begin
            exp_rv = 1'b1; exp_rd = mq[0].rd; exp_wen = mq[0].wen;
            exp_data = mq[0].data; exp_exc = mq[0].exc; exp_ridx = mq[0].idx;
         end
`ifdef CB_WB_FORWARD_EN
         else begin
            for (int p = NWB-1; p >= 0; p--) begin
               if (bus.wb_valid[p] && bus.wb_index[p*IW +: IW] == mq[0].idx) begin
                  exp_rv = 1'b1; exp_rd = mq[0].rd; exp_wen = mq[0].wen;
                  exp_data = bus.wb_data[p*DW +: DW]; exp_exc = bus.wb_exc[p];
                  exp_ridx = mq[0].idx;
               end
            end
         end
`endif
      end
   endtask

   task automatic model_next();
      int   sz;
      logic do_ret;
      logic found;
      ent_t ne;
      model_outputs();
      if (bus.flush) begin
         mq.delete();
         tail_ptr = 0;
         return;
      end
      sz     = mq.size();
      do_ret = exp_rv && bus.retire_ready;
      for (int i = 0; i < mq.size(); i++) begin
         found = 1'b0;
         for (int p = 0; p < NWB; p++) begin
            if (!found && bus.wb_valid[p] && bus.wb_index[p*IW +: IW] == mq[i].idx) begin
               found = 1'b1;
               mq[i].done = 1'b1;
               mq[i].data = bus.wb_data[p*DW +: DW];
               mq[i].exc  = bus.wb_exc[p];
            end
         end
      end
      if (do_ret) void'(mq.pop_front());
      if (bus.alloc_req && sz < N) begin
         ne.idx = IW'(tail_ptr % N); ne.rd = bus.alloc_rd; ne.wen = bus.alloc_wen;
         ne.done = 1'b0; ne.data = '0; ne.exc = 1'b0;
         mq.push_back(ne);
         tail_ptr = (tail_ptr + 1) % (2 * N);
      end
   endtask

   task automatic tick();
      model_next();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle();
      bus.alloc_req = 1'b0; bus.alloc_rd = '0; bus.alloc_wen = 1'b0;
      bus.wb_valid = '0; bus.wb_index = '0; bus.wb_data = '0; bus.wb_exc = '0;
      bus.retire_ready = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic set_wb(input int p, input logic [IW-1:0] idx, input logic [DW-1:0] d, input logic x);
      bus.wb_valid[p]          = 1'b1;
      bus.wb_index[p*IW +: IW] = idx;
      bus.wb_data[p*DW +: DW]  = d;
      bus.wb_exc[p]            = x;
   endtask

   task automatic do_alloc(input logic [4:0] rd);
      idle(); bus.alloc_req = 1'b1; bus.alloc_rd = rd; bus.alloc_wen = 1'b1;
      tick();
   endtask

   task automatic apply_reset();
      idle();
      nRST = 1'b0;
      #1;
      mq.delete();
      tail_ptr = 0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      nRST = 1'b1;
      #3 nRST = 1'b0;
      #1;
      checks++;
      if ({bus.alloc_ready, bus.alloc_index, bus.retire_valid, bus.retire_rd, bus.retire_wen,
           bus.retire_data, bus.retire_exc, bus.retire_index, bus.count} !==
          {1'b1, 4'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0, 5'd0}) begin
         errors++;
         $display("FAIL reset_state: ready=%b aidx=%0d rv=%b rd=%0d wen=%b data=%h exc=%b ridx=%0d count=%0d, want ready=1 and all others 0",
                  bus.alloc_ready, bus.alloc_index, bus.retire_valid, bus.retire_rd, bus.retire_wen,
                  bus.retire_data, bus.retire_exc, bus.retire_index, bus.count);
      end
      mq.delete();
      tail_ptr = 0;
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_in_order();
      logic [4:0]    got_rd[$];
      logic [DW-1:0] got_d[$];
      logic [DW-1:0] want_d [3] = '{32'hA, 32'hB, 32'hC};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         idle(); bus.alloc_req = 1'b1; bus.alloc_rd = 5'(i + 1); bus.alloc_wen = 1'b1;
         #1;
         checks++;
         if (bus.alloc_index !== IW'(i)) begin
            errors++; $display("FAIL alloc_index: got %0d want %0d", bus.alloc_index, i);
         end
         tick();
      end
      idle(); #1;
      checks++;
      if ({bus.count, bus.retire_valid} !== {5'd3, 1'b0}) begin
         errors++; $display("FAIL alloc3_state: count=%0d rv=%b want count=3 rv=0", bus.count, bus.retire_valid);
      end
      bus.retire_ready = 1'b1; set_wb(0, 4'd2, 32'hC, 1'b0); #1;
      checks++;
      if (bus.retire_valid !== 1'b0) begin
         errors++; $display("FAIL early_retire_a: rv=%b want 0", bus.retire_valid);
      end
      tick();
      idle(); bus.retire_ready = 1'b1; #1;
      checks++;
      if (bus.retire_valid !== 1'b0) begin
         errors++; $display("FAIL early_retire_b: rv=%b want 0", bus.retire_valid);
      end
      tick();
      for (int c = 0; c < 6; c++) begin
         idle(); bus.retire_ready = 1'b1;
         if (c == 0) set_wb(0, 4'd0, 32'hA, 1'b0);
         if (c == 1) set_wb(1, 4'd1, 32'hB, 1'b0);
         #1;
         if (bus.retire_valid) begin
            got_rd.push_back(bus.retire_rd);
            got_d.push_back(bus.retire_data);
         end
         tick();
      end
      checks++;
      if (got_rd.size() != 3) begin
         errors++; $display("FAIL retire_count: got %0d retires want 3", got_rd.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({got_rd[i], got_d[i]} !== {5'(i + 1), want_d[i]}) begin
               errors++;
               $display("FAIL retire_order[%0d]: rd=%0d data=%h want rd=%0d data=%h", i, got_rd[i], got_d[i], i + 1, want_d[i]);
            end
         end
      end
   endtask

   task automatic test_full_wrap();
      apply_reset();
      for (int i = 0; i < N; i++) begin
         idle(); bus.alloc_req = 1'b1; bus.alloc_rd = 5'(i); bus.alloc_wen = 1'b1;
         #1;
         checks++;
         if (bus.alloc_index !== IW'(i)) begin
            errors++; $display("FAIL fill_index: got %0d want %0d", bus.alloc_index, i);
         end
         tick();
      end
      idle(); bus.alloc_req = 1'b1; bus.alloc_rd = 5'd31; #1;
      checks++;
      if ({bus.alloc_ready, bus.count} !== {1'b0, 5'd16}) begin
         errors++; $display("FAIL full_state: ready=%b count=%0d want ready=0 count=16", bus.alloc_ready, bus.count);
      end
      tick();
      idle(); #1;
      checks++;
      if (bus.count !== 5'd16) begin
         errors++; $display("FAIL full_alloc_ignored: count=%0d want 16", bus.count);
      end
      set_wb(2, 4'd0, 32'h77, 1'b0);
      tick();
      idle(); bus.alloc_req = 1'b1; bus.alloc_rd = 5'd9; bus.retire_ready = 1'b1; #1;
      checks++;
      if ({bus.retire_valid, bus.retire_data, bus.alloc_ready} !== {1'b1, 32'h77, 1'b0}) begin
         errors++;
         $display("FAIL full_retire: rv=%b data=%h ready=%b want rv=1 data=77 ready=0", bus.retire_valid, bus.retire_data, bus.alloc_ready);
      end
      tick();
      idle(); bus.alloc_req = 1'b1; bus.alloc_rd = 5'd20; #1;
      checks++;
      if ({bus.alloc_ready, bus.count, bus.alloc_index} !== {1'b1, 5'd15, 4'd0}) begin
         errors++;
         $display("FAIL after_retire: ready=%b count=%0d aidx=%0d want ready=1 count=15 aidx=0", bus.alloc_ready, bus.count, bus.alloc_index);
      end
      tick();
      idle(); #1;
      checks++;
      if ({bus.alloc_ready, bus.count} !== {1'b0, 5'd16}) begin
         errors++; $display("FAIL wrap_alloc: ready=%b count=%0d want ready=0 count=16", bus.alloc_ready, bus.count);
      end
   endtask

   task automatic test_dual_wb_hold();
      apply_reset();
      for (int i = 0; i < 6; i++) do_alloc(5'(i + 10));
      idle();
      for (int p = 0; p < 4; p++) set_wb(p, IW'(p), 32'(256 + p), 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         idle(); bus.retire_ready = 1'b1; #1;
         checks++;
         if ({bus.retire_valid, bus.retire_index} !== {1'b1, IW'(i)}) begin
            errors++; $display("FAIL drain_head: rv=%b ridx=%0d want rv=1 ridx=%0d", bus.retire_valid, bus.retire_index, i);
         end
         tick();
      end
      idle(); set_wb(0, 4'd4, 32'h44, 1'b0); set_wb(3, 4'd5, 32'h55, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         idle(); #1;
         checks++;
         if ({bus.retire_valid, bus.retire_index, bus.retire_rd, bus.retire_data, bus.retire_exc, bus.count} !==
             {1'b1, 4'd4, 5'd14, 32'h44, 1'b0, 5'd2}) begin
            errors++;
            $display("FAIL hold[%0d]: rv=%b ridx=%0d rd=%0d data=%h exc=%b count=%0d want 1/4/14/44/0/2",
                     k, bus.retire_valid, bus.retire_index, bus.retire_rd, bus.retire_data, bus.retire_exc, bus.count);
         end
         tick();
      end
      idle(); bus.retire_ready = 1'b1; #1;
      checks++;
      if ({bus.retire_valid, bus.retire_index} !== {1'b1, 4'd4}) begin
         errors++; $display("FAIL release_4: rv=%b ridx=%0d want 1/4", bus.retire_valid, bus.retire_index);
      end
      tick();
      idle(); bus.retire_ready = 1'b1; #1;
      checks++;
      if ({bus.retire_valid, bus.retire_index, bus.retire_rd, bus.retire_data, bus.retire_exc} !==
          {1'b1, 4'd5, 5'd15, 32'h55, 1'b1}) begin
         errors++;
         $display("FAIL release_5: rv=%b ridx=%0d rd=%0d data=%h exc=%b want 1/5/15/55/1",
                  bus.retire_valid, bus.retire_index, bus.retire_rd, bus.retire_data, bus.retire_exc);
      end
      tick();
      idle(); #1;
      checks++;
      if ({bus.retire_valid, bus.count} !== {1'b0, 5'd0}) begin
         errors++; $display("FAIL drained: rv=%b count=%0d want 0/0", bus.retire_valid, bus.count);
      end
   endtask

   task automatic test_flush();
      apply_reset();
      for (int i = 0; i < 7; i++) do_alloc(5'(i + 1));
      idle(); set_wb(1, 4'd0, 32'hAA, 1'b0);
      tick();
      idle(); #1;
      checks++;
      if ({bus.count, bus.retire_valid} !== {5'd7, 1'b1}) begin
         errors++; $display("FAIL pre_flush: count=%0d rv=%b want 7/1", bus.count, bus.retire_valid);
      end
      bus.alloc_req = 1'b1; bus.alloc_rd = 5'd3; set_wb(0, 4'd1, 32'hBB, 1'b0);
      bus.retire_ready = 1'b1; bus.flush = 1'b1;
      tick();
      idle(); #1;
      checks++;
      if ({bus.count, bus.alloc_index, bus.retire_valid} !== {5'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL post_flush: count=%0d aidx=%0d rv=%b want 0/0/0", bus.count, bus.alloc_index, bus.retire_valid);
      end
      set_wb(0, 4'd0, 32'h12, 1'b0); set_wb(1, 4'd1, 32'h34, 1'b0); bus.retire_ready = 1'b1;
      tick();
      idle(); #1;
      checks++;
      if ({bus.count, bus.retire_valid} !== {5'd0, 1'b0}) begin
         errors++; $display("FAIL stale_wb: count=%0d rv=%b want 0/0", bus.count, bus.retire_valid);
      end
   endtask

   task automatic test_forward_latency();
      apply_reset();
      do_alloc(5'd7);
      idle(); set_wb(0, 4'd0, 32'h55, 1'b0); #1;
      checks++;
`ifdef CB_WB_FORWARD_EN
      if ({bus.retire_valid, bus.retire_data} !== {1'b1, 32'h55}) begin
         errors++; $display("FAIL fwd_same_cycle: rv=%b data=%h want 1/55", bus.retire_valid, bus.retire_data);
      end
`else
      if (bus.retire_valid !== 1'b0) begin
         errors++; $display("FAIL nofwd_same_cycle: rv=%b want 0", bus.retire_valid);
      end
`endif
      tick();
      idle(); #1;
      checks++;
      if ({bus.retire_valid, bus.retire_data, bus.retire_rd} !== {1'b1, 32'h55, 5'd7}) begin
         errors++;
         $display("FAIL wb_next_cycle: rv=%b data=%h rd=%0d want 1/55/7", bus.retire_valid, bus.retire_data, bus.retire_rd);
      end
   endtask

   task automatic test_random();
      logic [N-1:0]  used;
      logic [IW-1:0] idx;
      apply_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         idle();
         bus.alloc_req    = ($urandom_range(0, 9) < 6);
         bus.alloc_rd     = 5'($urandom);
         bus.alloc_wen    = 1'($urandom);
         bus.retire_ready = ($urandom_range(0, 9) < 7);
         bus.flush        = ($urandom_range(0, 59) == 0);
         used = '0;
         for (int p = 0; p < NWB; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                  idx = mq[$urandom_range(0, mq.size() - 1)].idx;
               else
                  idx = IW'($urandom_range(0, N - 1));
               if (!used[idx]) begin
                  used[idx] = 1'b1;
                  set_wb(p, idx, $urandom, 1'($urandom_range(0, 7) == 0));
               end
            end
         end
         #1;
         model_outputs();
         checks++;
         if ({bus.alloc_ready, bus.alloc_index, bus.count} !==
             {(mq.size() < N), IW'(tail_ptr % N), 5'(mq.size())}) begin
            errors++;
            $display("FAIL rand_alloc cyc %0d: ready=%b aidx=%0d count=%0d want ready=%b aidx=%0d count=%0d",
                     cyc, bus.alloc_ready, bus.alloc_index, bus.count, (mq.size() < N), tail_ptr % N, mq.size());
         end
         checks++;
         if ({bus.retire_valid, bus.retire_rd, bus.retire_wen, bus.retire_data, bus.retire_exc, bus.retire_index} !==
             {exp_rv, exp_rd, exp_wen, exp_data, exp_exc, exp_ridx}) begin
            errors++;
            $display("FAIL rand_retire cyc %0d: rv=%b rd=%0d wen=%b data=%h exc=%b ridx=%0d want rv=%b rd=%0d wen=%b data=%h exc=%b ridx=%0d",
                     cyc, bus.retire_valid, bus.retire_rd, bus.retire_wen, bus.retire_data, bus.retire_exc, bus.retire_index,
                     exp_rv, exp_rd, exp_wen, exp_data, exp_exc, exp_ridx);
         end
         tick();
      end
      // Asynchronous reset in the middle of a cycle with entries outstanding.
      for (int i = 0; i < 3; i++) do_alloc(5'(i + 1));
      idle();
      #2 nRST = 1'b0;
      #1;
      checks++;
      if ({bus.count, bus.alloc_index, bus.retire_valid, bus.alloc_ready} !== {5'd0, 4'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: count=%0d aidx=%0d rv=%b ready=%b want 0/0/0/1",
                  bus.count, bus.alloc_index, bus.retire_valid, bus.alloc_ready);
      end
      mq.delete();
      tail_ptr = 0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      tail_ptr = 0;
      nRST     = 1'b1;
      test_reset();
      test_in_order();
      test_full_wrap();
      test_dual_wb_hold();
      test_flush();
      test_forward_latency();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/completion_buffer.md
# completion_buffer

In-order completion buffer for the out-of-order-completion scalar back end. Decode allocates one entry per issued instruction and tags the functional-unit control bundle with the returned index (`index_a`, `index_mu`, `index_du`, `index_ls`). Arithmetic, multiply, divide and load/store units write results back out of order. The buffer then retires them to the register file strictly in program order. It generalises the fixed 16-entry, 4-unit arrangement to a configurable depth and writeback port count, and adds flush and occupancy reporting.

## Interface
- `NUM_ENTRY`, 16: buffer depth; power of two, ≥2. `IDX_W = $clog2(NUM_ENTRY)`.
- `NUM_WB`, 4: writeback ports. Port order is arith, mult, div, lsu; extra ports are appended.
- `DATA_W`, 32: result width (`WORD_SIZE`).
- `CLK` input 1: single clock, rising edge.
- `nRST` input 1: asynchronous, active-low reset.
- `alloc_req` input 1: decode requests an entry.
- `alloc_rd` input 5: destination register of the new entry.
- `alloc_wen` input 1: the entry writes the register file.
- `alloc_ready` output 1: the buffer is not full.
- `alloc_index` output IDX_W: index given to the requesting instruction; equals the tail.
- `wb_valid` input NUM_WB: per-port writeback strobe.
- `wb_index` input NUM_WB×IDX_W: target entry per port.
- `wb_data` input NUM_WB×DATA_W: result per port.
- `wb_exc` input NUM_WB: the result carries an exception.
- `retire_valid` output 1: the head entry is complete.
- `retire_ready` input 1: the commit stage accepts the head.
- `retire_rd` output 5, `retire_wen` output 1, `retire_data` output DATA_W, `retire_exc` output 1: head entry contents.
- `retire_index` output IDX_W: head index.
- `flush` input 1: discard all entries.
- `count` output IDX_W+1: current occupancy, 0..NUM_ENTRY.

## Operation
- Head and tail pointers are IDX_W+1 bits wide; the MSB is the wrap bit.
  - Empty when head == tail.
  - Full when the low bits are equal and the MSBs differ.
- Per-entry state: `valid`, `done`, `rd`, `wen`, `data`, `exc`.
- Allocate fires when `alloc_req && alloc_ready`.
  - The entry at the tail gets `valid=1`, `done=0` and captures `rd`/`wen`.
  - The tail advances by 1 and wraps modulo 2·NUM_ENTRY.
- Writeback on port p when `wb_valid[p]`:
  - If `valid[wb_index[p]]`, the entry gets `done=1` and captures `data`/`exc`.
  - A writeback to an invalid entry is ignored.
- Two ports targeting the same index in one cycle is illegal. The lowest-numbered port wins, and the bench flags it with an assertion.
- Retire fires when `retire_valid && retire_ready`.
  - The head entry is cleared (`valid=0`, `done=0`) and the head advances by 1.
  - Retire is not gated by `retire_exc`; the commit stage decides what to do with an exception and raises `flush` if needed.
- Simultaneous allocate and retire are both performed and `count` is unchanged.
  - When full, `alloc_ready=0` even if a retire happens in the same cycle; there is no same-cycle slot reuse.
- `flush` has priority over everything:
  - Next cycle, head = tail = 0 and every `valid`/`done` is 0.
  - Any allocate, writeback or retire in the flush cycle is discarded.
- `count` = tail − head, computed in IDX_W+1 bits.

## Timing
- Reset (`nRST` low, asynchronous, any time, including mid-operation):
  - head = tail = 0, all entry state is 0.
  - `alloc_ready=1`, `alloc_index=0`, `retire_valid=0`, `retire_rd=0`, `retire_wen=0`, `retire_data=0`, `retire_exc=0`, `retire_index=0`, `count=0`.
- `alloc_index` and `alloc_ready` are combinational from registered state and are stable for the whole cycle.
- An entry allocated at edge t can be written back in cycle t+1 or later.
- A writeback at edge t makes `retire_valid` rise in cycle t+1 at the earliest (without forwarding).
- Retire handshake: while `retire_valid=1` and `retire_ready=0`, all `retire_*` outputs are held stable.
- The `retire_*` outputs are 0 whenever `retire_valid=0`.

## Configuration
- `CB_WB_FORWARD_EN`, when defined:
  - If the head is valid and not done, and a port writes the head index this cycle, `retire_valid` asserts in the same cycle with the forwarded `data`/`exc`.
  - Retire latency drops to 0 cycles after writeback.
  - This adds a combinational path from `wb_*` to `retire_*`.
- Not defined: `retire_*` is driven only from registered entry state, with a 1-cycle minimum latency from writeback to retire.

## Test plan
- Reset, then allocate 3 entries (rd=1,2,3) → `alloc_index` 0,1,2; `count=3`; `retire_valid=0`.
- Write back entries in order 2, 0, 1 (data 0xC, 0xA, 0xB) with `retire_ready=1` → retires rd1/0xA, rd2/0xB, rd3/0xC in order. Nothing retires before entry 0 completes.
- Fill all 16 entries → `alloc_ready=0`, `count=16`. An `alloc_req` in that state is ignored. Retire 1 → `alloc_ready=1`. The next allocate returns index 0 with the wrap bit set.
- Ports 0 and 3 write back the same cycle to indices 4 and 5; the head is at 4 with `retire_ready=0` → both entries done, outputs held. Raising `retire_ready` retires 4 and then 5 on consecutive cycles.
- `flush` in the same cycle as alloc, writeback and retire, with `count=7` → next cycle `count=0`, `alloc_index=0`, `retire_valid=0`.
- With `CB_WB_FORWARD_EN`: head entry 0 is written back with 0x55 in cycle t → `retire_valid=1` and `retire_data=0x55` in cycle t. Without the macro, the same stimulus gives `retire_valid=1` in cycle t+1.
